// File: rtl/in_block_rx_if.sv
// rtl/in_block_rx_if.sv - CPU/UART-side signal bundle for the in_block_rx input unit
interface in_block_rx_if #(
  parameter int CHARS_PER_WORD = 5,
  parameter int ADDR_W         = 12
);
  localparam int W = 6 * CHARS_PER_WORD;

  logic              start;
  logic [ADDR_W-1:0] addressin;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              store;
  logic [W-1:0]      out;
  logic [ADDR_W-1:0] addressout;
  logic              request;
  logic              stop;
  logic              busy;
  logic              overrun;

  modport slave (
    input  start, addressin, byte_in, byte_valid, store,
    output out, addressout, request, stop, busy, overrun
  );

  modport master (
    output start, addressin, byte_in, byte_valid, store,
    input  out, addressout, request, stop, busy, overrun
  );
endinterface

// File: rtl/in_block_rx.sv
// rtl/in_block_rx.sv - ASCII-to-MIX block input unit with word FIFO and queued IN
// Define IN_LCFOLD_EN to map lowercase a-z onto the A-Z codes.
module in_block_rx #(
  parameter int CHARS_PER_WORD  = 5,
  parameter int WORDS_PER_BLOCK = 16,
  parameter int FIFO_DEPTH      = 4,
  parameter int ADDR_W          = 12
) (
  input  logic          clk,
  input  logic          reset_n,
  in_block_rx_if.slave  rx_if
);
  localparam int W  = 6 * CHARS_PER_WORD;
  localparam int CW = $clog2(CHARS_PER_WORD + 1);
  localparam int WC = $clog2(WORDS_PER_BLOCK + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_CHAR = CW'(CHARS_PER_WORD - 1);
  localparam logic [WC-1:0] LAST_WORD = WC'(WORDS_PER_BLOCK - 1);
  localparam logic [PW:0]   FULL      = (PW + 1)'(FIFO_DEPTH);
  localparam logic [PW:0]   ONE       = (PW + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAD, S_DRAIN} state_t;

  function automatic logic [5:0] mix_code(input logic [7:0] b);
    logic [7:0] u;
    logic [5:0] c;
    u = b;
`ifdef IN_LCFOLD_EN
    if (b >= 8'h61 && b <= 8'h7A) u = b - 8'h20;
`endif
    c = 6'd0;
    if (u >= 8'h41 && u <= 8'h49)      c = 6'(u - 8'h40);
    else if (u >= 8'h4A && u <= 8'h52) c = 6'(u - 8'h3F);
    else if (u >= 8'h53 && u <= 8'h5A) c = 6'(u - 8'h3D);
    else if (u >= 8'h30 && u <= 8'h39) c = 6'(u - 8'h12);
    else begin
      case (u)
        8'h2E: c = 6'd40;  8'h2C: c = 6'd41;  8'h28: c = 6'd42;  8'h29: c = 6'd43;
        8'h2B: c = 6'd44;  8'h2D: c = 6'd45;  8'h2A: c = 6'd46;  8'h2F: c = 6'd47;
        8'h3D: c = 6'd48;  8'h24: c = 6'd49;  8'h3C: c = 6'd50;  8'h3E: c = 6'd51;
        8'h40: c = 6'd52;  8'h3B: c = 6'd53;  8'h3A: c = 6'd54;  8'h27: c = 6'd55;
        default: c = 6'd0;
      endcase
    end
    return c;
  endfunction

  state_t            state_q, state_d;
  logic              stop_q, stop_d;
  logic              overrun_q, overrun_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]     char_cnt_q, char_cnt_d;
  logic [WC-1:0]     word_cnt_q, word_cnt_d;
  logic [W-1:0]      shift_q, shift_d;
  logic [W-1:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]       count_q, count_d;

  logic         busy, request, fifo_full;
  logic         char_due, word_done, push, take, pop;
  logic [5:0]   char_val;
  logic [W-1:0] new_word;

  assign busy      = (state_q != S_IDLE);
  assign fifo_full = (count_q == FULL);
  assign request   = busy && (count_q != '0);
  assign pop       = rx_if.store && request;

  // PAD feeds a zero character every cycle; RUN takes printable bytes only
  assign char_due  = (state_q == S_PAD) ||
                     (state_q == S_RUN && rx_if.byte_valid && rx_if.byte_in >= 8'h20);
  assign char_val  = (state_q == S_PAD) ? 6'd0 : mix_code(rx_if.byte_in);
  assign word_done = char_due && (char_cnt_q == LAST_CHAR);
  assign push      = word_done && !fifo_full;
  assign take      = char_due && !(word_done && fifo_full);
  assign new_word  = (shift_q << 6) | W'(char_val);

  always_comb begin
    state_d     = state_q;
    stop_d      = 1'b0;
    overrun_d   = overrun_q;
    pending_d   = pending_q;
    pend_addr_d = pend_addr_q;
    addr_d      = addr_q;
    char_cnt_d  = char_cnt_q;
    word_cnt_d  = word_cnt_q;
    shift_d     = shift_q;
    count_d     = count_q;

    if (push && !pop)      count_d = count_q + ONE;
    else if (pop && !push) count_d = count_q - ONE;

    if (take) begin
      if (word_done) begin
        char_cnt_d = '0;
        shift_d    = '0;
        word_cnt_d = word_cnt_q + 1'b1;
      end else begin
        char_cnt_d = char_cnt_q + 1'b1;
        shift_d    = new_word;
      end
    end
    if (state_q == S_RUN && word_done && fifo_full) overrun_d = 1'b1;
    if (pop) addr_d = addr_q + 1'b1;
    if (rx_if.start && busy && !pending_q) begin
      pending_d   = 1'b1;
      pend_addr_d = rx_if.addressin;
      overrun_d   = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_if.start) begin
          state_d   = S_RUN;
          addr_d    = rx_if.addressin;
          stop_d    = 1'b1;
          overrun_d = 1'b0;
        end
      end
      S_RUN: begin
        if (push && word_cnt_q == LAST_WORD) state_d = S_DRAIN;
        else if (rx_if.byte_valid && rx_if.byte_in == 8'h0D) state_d = S_PAD;
      end
      S_PAD: begin
        if (push && word_cnt_q == LAST_WORD) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // A start landing on the handover cycle itself is taken as the queued IN
        if (pop && count_q == ONE) begin
          word_cnt_d = '0;
          if (pending_q || rx_if.start) begin
            addr_d    = pending_q ? pend_addr_q : rx_if.addressin;
            pending_d = 1'b0;
            stop_d    = 1'b1;
            state_d   = S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      stop_q      <= 1'b0;
      overrun_q   <= 1'b0;
      pending_q   <= 1'b0;
      pend_addr_q <= '0;
      addr_q      <= '0;
      char_cnt_q  <= '0;
      word_cnt_q  <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      stop_q      <= stop_d;
      overrun_q   <= overrun_d;
      pending_q   <= pending_d;
      pend_addr_q <= pend_addr_d;
      addr_q      <= addr_d;
      char_cnt_q  <= char_cnt_d;
      word_cnt_q  <= word_cnt_d;
      shift_q     <= shift_d;
      count_q     <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= new_word;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign rx_if.out        = mem_q[rd_ptr_q];
  assign rx_if.addressout = addr_q;
  assign rx_if.request    = request;
  assign rx_if.stop       = stop_q;
  assign rx_if.busy       = busy;
  assign rx_if.overrun    = overrun_q;
endmodule

// File: tb/tb_in_block_rx.sv
// tb/tb_in_block_rx.sv - scoreboard bench for in_block_rx with a string-table reference model
module tb_in_block_rx;
  localparam int CPW = 5;
  localparam int WPB = 16;
  localparam int DEPTH = 4;
  localparam int AW = 12;
  localparam int W = 6 * CPW;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [W-1:0]  data;
    logic [AW-1:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  in_block_rx_if #(.CHARS_PER_WORD(CPW), .ADDR_W(AW)) bus();

  in_block_rx #(
    .CHARS_PER_WORD(CPW), .WORDS_PER_BLOCK(WPB), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rx_if(bus)
  );

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   stop_cnt = 0;
  bit   cpu_en = 1'b0;
  bit   man_store = 1'b0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Code = position of the character in the MIX table; '~' marks unused codes
  function automatic logic [5:0] ref_code(input logic [7:0] b);
    string tbl;
    logic [7:0] c;
    tbl = " ABCDEFGHI~JKLMNOPQR~~STUVWXYZ0123456789.,()+-*/=$<>@;:'";
    c = b;
`ifdef IN_LCFOLD_EN
    if (c >= 8'h61 && c <= 8'h7A) c = c - 8'h20;
`endif
    for (int i = 0; i < 56; i++)
      if (tbl[i] != 8'h7E && tbl[i] == c) return 6'(i);
    return 6'd0;
  endfunction

  task automatic model_block(input bq_t bytes, input logic [AW-1:0] base);
    logic [5:0] codes[$];
    logic [W-1:0] word;
    foreach (bytes[i]) begin
      if (codes.size() == CPW * WPB) break;
      if (bytes[i] < 8'h20) begin
        if (bytes[i] == 8'h0D) break;
      end else begin
        codes.push_back(ref_code(bytes[i]));
      end
    end
    while (codes.size() < CPW * WPB) codes.push_back(6'd0);
    for (int w = 0; w < WPB; w++) begin
      word = '0;
      for (int k = 0; k < CPW; k++) word = (word << 6) | W'(codes[w * CPW + k]);
      exp_q.push_back({word, AW'(base + AW'(w))});
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && bus.stop) stop_cnt++;
    if (reset_n && bus.request && bus.store) begin
      if (exp_q.size() == 0) begin
        check("unexpected_store", 64'(bus.addressout), 64'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("word_data", 64'(bus.out), 64'(e.data));
        check("word_addr", 64'(bus.addressout), 64'(e.addr));
      end
    end
  end

  initial begin
    bit s, waited;
    bus.store = 1'b0;
    waited = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (cpu_en) begin
        s = bus.request && (waited || $urandom_range(0, 1) == 1);
        waited = bus.request && !s;
        bus.store = s;
      end else begin
        waited = 1'b0;
        bus.store = man_store;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.byte_in = b;
    bus.byte_valid = 1'b1;
    tick();
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_q(input bq_t q, input int max_gap);
    foreach (q[i]) begin
      send_byte(q[i]);
      repeat ($urandom_range(0, max_gap)) tick();
    end
  endtask

  task automatic str2q(input string s, output bq_t q);
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endtask

  task automatic do_start(input logic [AW-1:0] a);
    bus.addressin = a;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy && n < 3000) begin
      tick();
      n++;
    end
    check(name, 64'(bus.busy), 64'd0);
  endtask

  function automatic logic [7:0] rand_byte();
    string punct;
    string other;
    int r;
    punct = ".,()+-*/=$<>@;:'";
    other = "!\"#%&?[]^_`{|}~";
    r = $urandom_range(0, 99);
    if (r < 1) return 8'h0D;
    if (r < 5) begin
      logic [7:0] c;
      c = 8'($urandom_range(0, 31));
      return (c == 8'h0D) ? 8'h09 : c;
    end
    if (r < 40) return 8'(8'h41 + $urandom_range(0, 25));
    if (r < 55) return 8'(8'h61 + $urandom_range(0, 25));
    if (r < 70) return 8'(8'h30 + $urandom_range(0, 9));
    if (r < 85) return punct[$urandom_range(0, punct.len() - 1)];
    if (r < 92) return 8'h20;
    return other[$urandom_range(0, other.len() - 1)];
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bq_t q, q2;
    int s0, n, nchar;
    logic [7:0] b;
    logic [AW-1:0] base;

    bus.start = 1'b0;
    bus.addressin = '0;
    bus.byte_in = '0;
    bus.byte_valid = 1'b0;
    reset_n = 1'b0;
    repeat (3) tick();
    check("rst_out", 64'(bus.out), 64'd0);
    check("rst_addressout", 64'(bus.addressout), 64'd0);
    check("rst_request", 64'(bus.request), 64'd0);
    check("rst_stop", 64'(bus.stop), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_overrun", 64'(bus.overrun), 64'd0);
    reset_n = 1'b1;
    tick();

    // Idle bytes are dropped: nothing may appear
    send_byte(8'h41);
    tick();
    check("idle_no_request", 64'(bus.request), 64'd0);

    // First word "ABCDE", then "AB" + CR pads the rest of the block
    str2q("ABCDEAB", q);
    q.push_back(8'h0D);
    model_block(q, 12'h100);
    s0 = stop_cnt;
    do_start(12'h100);
    check("stop_after_start", 64'(bus.stop), 64'd1);
    check("busy_after_start", 64'(bus.busy), 64'd1);
    str2q("ABCDE", q);
    send_q(q, 0);
    check("req_latency", 64'(bus.request), 64'd1);
    check("first_word", 64'(bus.out), 64'h1083105);
    check("first_addr", 64'(bus.addressout), 64'h100);
    check("stop_one_pulse", 64'(stop_cnt - s0), 64'd1);
    man_store = 1'b1;
    tick();
    man_store = 1'b0;
    check("addr_after_store", 64'(bus.addressout), 64'h101);
    check("req_after_store", 64'(bus.request), 64'd0);
    s0 = stop_cnt;
    cpu_en = 1'b1;
    str2q("AB", q);
    q.push_back(8'h0D);
    send_q(q, 1);
    wait_idle("pad_block_idle");
    check("pad_block_no_stop", 64'(stop_cnt - s0), 64'd0);
    cpu_en = 1'b0;

    // Overrun: no stores, 25 chars -> 4 words held and the 25th char dropped
    q = {};
    for (int i = 0; i < 25; i++) q.push_back(8'(8'h41 + $urandom_range(0, 25)));
    q2 = q;
    void'(q2.pop_back());
    q2.push_back(8'h0D);
    model_block(q2, 12'h300);
    do_start(12'h300);
    send_q(q, 0);
    tick();
    check("overrun_set", 64'(bus.overrun), 64'd1);
    check("overrun_request", 64'(bus.request), 64'd1);
    s0 = stop_cnt;
    do_start(12'h200);
    check("overrun_cleared", 64'(bus.overrun), 64'd0);
    check("pending_no_stop", 64'(bus.stop), 64'd0);
    cpu_en = 1'b1;
    send_byte(8'h0D);
    n = 0;
    while (!bus.stop && n < 3000) begin
      tick();
      n++;
    end
    check("handover_stop", 64'(bus.stop), 64'd1);
    check("handover_no_early_stop", 64'(stop_cnt - s0), 64'd0);
    check("handover_addr", 64'(bus.addressout), 64'h200);
    check("handover_busy", 64'(bus.busy), 64'd1);
    check("handover_drained", 64'(exp_q.size()), 64'd0);
    tick();
    check("handover_stop_1cyc", 64'(bus.stop), 64'd0);
    str2q("CDEFG", q);
    q.push_back(8'h0D);
    model_block(q, 12'h200);
    send_q(q, 1);
    wait_idle("queued_block_idle");
    cpu_en = 1'b0;

    // Asynchronous reset mid-word
    do_start(12'h400);
    str2q("AB", q);
    send_q(q, 0);
    #3 reset_n = 1'b0;
    #1;
    check("arst_out", 64'(bus.out), 64'd0);
    check("arst_addressout", 64'(bus.addressout), 64'd0);
    check("arst_request", 64'(bus.request), 64'd0);
    check("arst_stop", 64'(bus.stop), 64'd0);
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_overrun", 64'(bus.overrun), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    str2q("CDEFG", q);
    q.push_back(8'h0D);
    model_block(q, 12'h500);
    do_start(12'h500);
    cpu_en = 1'b1;
    send_q(q, 0);
    wait_idle("post_reset_idle");

    // Lowercase, digit and punctuation edge codes
    str2q("a9@ZJ", q);
    q.push_back(8'h0D);
    model_block(q, 12'h600);
    do_start(12'h600);
    send_q(q, 0);
    wait_idle("codes_idle");

    // Random blocks; the first one wraps the address space
    for (int blk = 0; blk < 6; blk++) begin
      q = {};
      nchar = 0;
      while (nchar < CPW * WPB) begin
        b = rand_byte();
        q.push_back(b);
        if (b == 8'h0D) break;
        if (b >= 8'h20) nchar++;
      end
      base = (blk == 0) ? 12'hFF8 : AW'($urandom_range(0, 4095));
      model_block(q, base);
      s0 = stop_cnt;
      do_start(base);
      check("rand_stop", 64'(bus.stop), 64'd1);
      send_q(q, 2);
      wait_idle("rand_idle");
    end
    cpu_en = 1'b0;
    tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
